bof_range_buffer: RTL

- Circular store of heap-overflow address ranges. The store-run tracker in the ALU path writes to it; load-side checks query it.
- Receives completed ranges (first/last byte address) on a one-cycle write strobe and keeps the newest DEPTH ranges, oldest overwritten.
- Answers "is this address inside any recorded range" combinationally, so the tracker sees the result in the same cycle.
- Also flags read overflows (a load run starting outside a range and entering it), and supports a sequential user clear sweep.

---
 rtl/bof_range_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bof_range_buffer.sv
// Circular store of heap-overflow address ranges with combinational lookup and a sequential clear sweep.
// Optional BOF_RANGE_MERGE_EN: merge a write into the newest entry when the two ranges overlap or touch.
module bof_range_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_first_i,
    input  logic [AW-1:0]    wr_last_i,
    input  logic [AW-1:0]    find_addr_i,
    input  logic [AW-1:0]    base_addr_i,
    output logic             addr_in_range_o,
    output logic             read_overflow_o,
    output logic [AW-1:0]    read_o,
    output logic [AW-1:0]    read2_o,
    output logic [PTR_W:0]   count_o,
    output logic             busy_o
);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

    state_e             state_q, state_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [AW-1:0]      lo_q [DEPTH];
    logic [AW-1:0]      lo_d [DEPTH];
    logic [AW-1:0]      hi_q [DEPTH];
    logic [AW-1:0]      hi_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   idx_q, idx_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [AW-1:0]      read_q, read_d;
    logic [AW-1:0]      read2_q, read2_d;
    logic               rof_q, rof_d;
    logic               busy_q, busy_d;

    logic [AW-1:0]      new_lo, new_hi;
    logic [PTR_W-1:0]   newest_q, newest_d;
    logic               merge_hit;
    logic               find_hit;
    logic               overflow_hit;

    always_comb begin
        new_lo   = (wr_first_i <= wr_last_i) ? wr_first_i : wr_last_i;
        new_hi   = (wr_first_i <= wr_last_i) ? wr_last_i  : wr_first_i;
        newest_q = wr_ptr_q - 1'b1;
`ifdef BOF_RANGE_MERGE_EN
        // Widened to AW+1 bits so hi+1 cannot wrap to zero at the top of memory.
        merge_hit = (count_q != '0) && valid_q[newest_q]
                 && ({1'b0, new_lo} <= ({1'b0, hi_q[newest_q]} + (AW+1)'(1)))
                 && (({1'b0, new_hi} + (AW+1)'(1)) >= {1'b0, lo_q[newest_q]});
`else
        merge_hit = 1'b0;
`endif
    end

    always_comb begin
        find_hit     = 1'b0;
        overflow_hit = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid_q[k] && (lo_q[k] <= find_addr_i) && (find_addr_i <= hi_q[k])) begin
                find_hit = 1'b1;
                if (!((lo_q[k] <= base_addr_i) && (base_addr_i <= hi_q[k])))
                    overflow_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        wr_ptr_d = wr_ptr_q;
        idx_d    = idx_q;
        count_d  = count_q;
        busy_d   = busy_q;
        rof_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    rof_d = overflow_hit;
                    if (wr_en_i) begin
                        if (merge_hit) begin
                            lo_d[newest_q] = (new_lo < lo_q[newest_q]) ? new_lo : lo_q[newest_q];
                            hi_d[newest_q] = (new_hi > hi_q[newest_q]) ? new_hi : hi_q[newest_q];
                        end else begin
                            lo_d[wr_ptr_q]    = new_lo;
                            hi_d[wr_ptr_q]    = new_hi;
                            valid_d[wr_ptr_q] = 1'b1;
                            wr_ptr_d          = wr_ptr_q + 1'b1;
                            if (count_q != (PTR_W+1)'(DEPTH))
                                count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                valid_d[idx_q] = 1'b0;
                idx_d          = idx_q + 1'b1;
                if (idx_q == PTR_W'(DEPTH - 1)) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs track the post-update state so a write shows up exactly one cycle later.
        newest_d = wr_ptr_d - 1'b1;
        read_d   = (count_d != '0) ? lo_d[newest_d] : '0;
        read2_d  = (count_d != '0) ? hi_d[newest_d] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            read_q   <= '0;
            read2_q  <= '0;
            rof_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            read_q   <= read_d;
            read2_q  <= read2_d;
            rof_q    <= rof_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
    end

    assign addr_in_range_o = find_hit;
    assign read_overflow_o = rof_q;
    assign read_o          = read_q;
    assign read2_o         = read2_q;
    assign count_o         = count_q;
    assign busy_o          = busy_q;

endmodule
